// File: rtl/nibble_alu_seq.sv
// nibble_alu_seq
//   Sequential 4-bit arithmetic unit. The active-low KEY_GO pushbutton is
//   synchronized and debounced. Each debounced press latches the operands and
//   the op select, then runs one operation:
//     - ADD and SUB take a single CALC cycle.
//     - MUL is a 4-step shift-add.
//     - DIV is a 4-step restoring divide.
//   The 8-bit RESULT feeds two hex-digit decoders: [3:0] low digit, [7:4] high.
//
// Ports
//   CLK      in   1  system clock, rising edge
//   RST_N    in   1  asynchronous active-low reset
//   SW_A     in   4  operand A, unsigned
//   SW_B     in   4  operand B, unsigned
//   SW_SEL0  in   1  op select bit 0
//   SW_SEL1  in   1  op select bit 1 (00 ADD, 01 SUB, 10 MUL, 11 DIV)
//   KEY_GO   in   1  pushbutton, 0 = pressed, asynchronous to CLK
//   RESULT   out  8  registered result; DIV packs {remainder, quotient}
//   BUSY     out  1  high while an operation is in flight
//   DONE     out  1  one-cycle pulse on the edge RESULT updates
//   ERR      out  1  divide-by-zero flag, held until the next accepted op
module nibble_alu_seq #(
  parameter int DB_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] SW_A,
  input  logic [3:0] SW_B,
  input  logic       SW_SEL0,
  input  logic       SW_SEL1,
  input  logic       KEY_GO,
  output logic [7:0] RESULT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  state_t state, state_next;

  logic             key_s1, key_s2;
  logic             db_level, db_prev;
  logic [CNT_W-1:0] db_cnt;
  logic             go;

  logic [1:0] iter;
  logic       iter_last;

  op_t        op;
  logic [3:0] op_a, op_b;
  logic [7:0] acc;
  logic [7:0] mcand;
  logic [3:0] mplier;
  logic [4:0] rem;
  logic [3:0] quot;

  // Single-cycle add/subtract. The difference is formed as a signed value
  // and truncated to 8 bits, giving two's complement wrap (3-5 = 8'hFE).
  function automatic logic [7:0] addsub(input logic [3:0] a, input logic [3:0] b,
                                        input logic sub);
    logic signed [8:0] diff;
    diff = $signed({5'b0, a}) - $signed({5'b0, b});
    return sub ? diff[7:0] : ({4'b0, a} + {4'b0, b});
  endfunction

  // One shift-add multiply step: add the shifted multiplicand when the
  // current multiplier LSB is set.
  function automatic logic [7:0] mul_acc(input logic [7:0] a_acc,
                                         input logic [7:0] a_mcand,
                                         input logic       a_bit);
    return a_bit ? (a_acc + a_mcand) : a_acc;
  endfunction

  // One restoring-divide step. The next dividend bit shifts into the partial
  // remainder. The divisor is subtracted only if it fits. The quotient register
  // doubles as the dividend shift register.
  function automatic logic [8:0] div_step(input logic [4:0] a_rem,
                                          input logic [3:0] a_quot,
                                          input logic [3:0] a_div);
    logic [5:0] sh;
    sh = {a_rem, a_quot[3]};
    if (sh >= {2'b0, a_div})
      return {5'(sh - {2'b0, a_div}), a_quot[2:0], 1'b1};
    else
      return {5'(sh), a_quot[2:0], 1'b0};
  endfunction

  // Key input: two-flop synchronizer, then debounce. The debounced level
  // only follows the synced level after DB_CYCLES consecutive differing
  // samples. Any agreeing sample restarts the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      db_level <= 1'b1;
      db_prev  <= 1'b1;
      db_cnt   <= '0;
    end else begin
      key_s1  <= KEY_GO;
      key_s2  <= key_s1;
      db_prev <= db_level;
      if (key_s2 == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= key_s2;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Press = debounced falling edge; a held key therefore yields one pulse.
  assign go = db_prev & ~db_level;

  assign iter_last = (op == OP_MUL || op == OP_DIV) ? (iter == 2'd3) : (iter == 2'd0);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (go) state_next = CALC;
      CALC:    if (iter_last) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign BUSY = (state != IDLE);

  // Control: state, iteration count and the visible outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      iter   <= '0;
      RESULT <= '0;
      DONE   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      state <= state_next;
      DONE  <= (state == FINISH);
      if (state == IDLE && go) begin
        iter <= '0;
        ERR  <= 1'b0;
      end else if (state == CALC) begin
        iter <= iter + 1'b1;
      end
      if (state == FINISH) begin
        if (op == OP_DIV) begin
          RESULT <= (op_b == 4'd0) ? 8'hFF : {rem[3:0], quot};
          ERR    <= (op_b == 4'd0);
        end else begin
          RESULT <= acc;
        end
      end
    end
  end

  // Datapath: operands are captured at the accepting edge, so later switch
  // movement cannot disturb the operation in flight.
  always_ff @(posedge CLK) begin
    if (state == IDLE && go) begin
      op     <= op_t'({SW_SEL1, SW_SEL0});
      op_a   <= SW_A;
      op_b   <= SW_B;
      acc    <= '0;
      mcand  <= {4'b0, SW_A};
      mplier <= SW_B;
      rem    <= '0;
      quot   <= SW_A;
    end else if (state == CALC) begin
      unique case (op)
        OP_ADD: acc <= addsub(op_a, op_b, 1'b0);
        OP_SUB: acc <= addsub(op_a, op_b, 1'b1);
        OP_MUL: begin
          acc    <= mul_acc(acc, mcand, mplier[0]);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
        end
        OP_DIV: {rem, quot} <= div_step(rem, quot, op_b);
        default: acc <= acc;
      endcase
    end
  end

endmodule
